// File: rtl/uart_cmd_resp_if.sv
// Command/response handshake between the UART link block and the command processor.
interface uart_cmd_resp_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        snd_resp;
  logic        resp_sent;

  // master: command processor side
  modport master (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp, snd_resp
  );

  // slave: UART link side
  modport slave (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp, snd_resp
  );
endinterface

// File: rtl/uart_cmd_resp.sv
// Knight-side RemoteComm link: assembles 16-bit commands from two UART bytes
// (high byte first) and serializes 8-bit responses. RX and TX are independent.
module uart_cmd_resp #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RX,
  output logic            TX,
  uart_cmd_resp_if.slave  bus
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_TXING} tx_state_t;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [BIT_W-1:0] rx_bits;
  logic [7:0]       rx_shift;
  logic             rx_rdy;
  logic             frame_err;
  logic             start_det_c;

  asm_state_t       asm_state;
  logic [7:0]       hi_reg;
  logic [15:0]      cmd_q;
  logic             cmd_rdy_q;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [BIT_W-1:0] tx_bits;
  logic [8:0]       tx_shift;
  logic             tx_q;
  logic             resp_sent_q;

  assign start_det_c   = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.resp_sent = resp_sent_q;
  assign TX            = tx_q;

  // Two-flop synchronizer plus one delay flop for falling-edge detection; all idle high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM: mid-bit sampling, false-start rejection, framing check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bits   <= '0;
      rx_shift  <= '0;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (start_det_c) begin
            rx_cnt   <= HALF_LOAD;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end else if (rx_sync) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt   <= BIT_LOAD;
            rx_bits  <= '0;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end else begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= BIT_LOAD;
            rx_bits  <= rx_bits + BIT_W'(1);
            if (rx_bits == BIT_W'(7)) begin
              rx_state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end else begin
            rx_rdy    <= rx_sync;
            frame_err <= !rx_sync;
            rx_state  <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Byte assembler and cmd_rdy: a completing low byte beats any clear on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_state <= ASM_HIGH;
      hi_reg    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      if (frame_err) begin
        asm_state <= ASM_HIGH;
      end else if (rx_rdy) begin
        if (asm_state == ASM_HIGH) begin
          hi_reg    <= rx_shift;
          asm_state <= ASM_LOW;
        end else begin
          cmd_q     <= {hi_reg, rx_shift};
          asm_state <= ASM_HIGH;
        end
      end

      if (rx_rdy && (asm_state == ASM_LOW)) begin
        cmd_rdy_q <= 1'b1;
      end else if (bus.clr_cmd_rdy || (start_det_c && (asm_state == ASM_HIGH))) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  // Transmit FSM: start bit goes out on acceptance, each bit held BAUD_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_bits     <= '0;
      tx_shift    <= '1;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.snd_resp) begin
            tx_shift    <= {1'b1, bus.resp};
            tx_q        <= 1'b0;
            tx_cnt      <= BIT_LOAD;
            tx_bits     <= '0;
            resp_sent_q <= 1'b0;
            tx_state    <= TX_TXING;
          end
        end
        TX_TXING: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CNT_W'(1);
          end else if (tx_bits == BIT_W'(9)) begin
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b1;
            tx_state    <= TX_IDLE;
          end else begin
            tx_q     <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bits  <= tx_bits + BIT_W'(1);
            tx_cnt   <= BIT_LOAD;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
